skew_matrix_buf: RTL

Parametrised DIM×DIM operand buffer for the systolic matrix-multiply array. It loads a signed matrix one vector per cycle, either as a row or as a column, so transposition is selectable per write. On `start` it streams the matrix into the array with diagonal skew: row r is delayed r cycles and framed by a per-row valid. It replaces a bank of per-row transpose FIFOs with one addressable store, a stream counter and a start/busy/done handshake.

---
 rtl/skew_matrix_buf.sv | 123 ++++++++++++
 1 files changed

// File: rtl/skew_matrix_buf.sv
// DIMxDIM signed operand store, written by row or column, streamed out with a diagonal skew.
// Start latency 1 cycle; en=0 stalls the stream; writes/clear are accepted only while idle.
module skew_matrix_buf #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            WrEn,
  input  logic                            col_mode,
  input  logic [$clog2(DIM)-1:0]          Aidx,
  input  logic [DIM-1:0][BITS_AB-1:0]     Ain,
  input  logic                            clear,
  input  logic                            start,
  output logic [DIM-1:0][BITS_AB-1:0]     Aout,
  output logic [DIM-1:0]                  Avalid,
  output logic                            busy,
  output logic                            done
);
  localparam int IW = $clog2(DIM);
  localparam int TW = $clog2(2*DIM);
  localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                                  state_q, state_d;
  logic [TW-1:0]                           t_q, t_d;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0]    mat_q, mat_d;
  logic [DIM-1:0][BITS_AB-1:0]             aout_q, aout_d;
  logic [DIM-1:0]                          avalid_q, avalid_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;
  logic                                    load;
  logic [TW-1:0]                           step_t;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    mat_d    = mat_q;
    aout_d   = aout_q;
    avalid_d = avalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    step_t   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end else if (clear) begin
          mat_d = '0;
        end else if (WrEn) begin
          if (col_mode) begin
            for (int i = 0; i < DIM; i++) mat_d[i][Aidx] = Ain[i];
          end else begin
            mat_d[Aidx] = Ain;
          end
        end
      end
      STREAM: begin
        if (en) begin
          if (t_q == T_LAST) begin
            state_d  = IDLE;
            t_d      = '0;
            aout_d   = '0;
            avalid_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            t_d    = t_q + 1'b1;
            step_t = t_q + 1'b1;
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane r carries column (t - r) of row r while that column index is in range.
    if (load) begin
      for (int r = 0; r < DIM; r++) begin
        if (int'(step_t) >= r && int'(step_t) < r + DIM) begin
          aout_d[r]   = mat_q[r][IW'(int'(step_t) - r)];
          avalid_d[r] = 1'b1;
        end else begin
          aout_d[r]   = '0;
          avalid_d[r] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      mat_q    <= '0;
      aout_q   <= '0;
      avalid_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      mat_q    <= mat_d;
      aout_q   <= aout_d;
      avalid_q <= avalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Aout   = aout_q;
  assign Avalid = avalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
